mmio_console: RTL and testbench

MMIO_CONSOLE -- requirements
Module: mmio_console

---
 rtl/mmio_console_if.sv | 24 ++
 rtl/mmio_console.sv | 108 ++++++++++
 tb/tb_mmio_console.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mmio_console_if.sv
// Core data-memory port plus the TX byte stream of the MMIO console.
// The master side is the core/testbench, the slave side is the console.
interface mmio_console_if;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_rdata;
    logic        bus_sel;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output bus_addr, bus_we, bus_re, bus_wdata, bus_wstrb, tx_ready,
        input  bus_rdata, bus_sel, tx_data, tx_valid
    );

    modport slave (
        input  bus_addr, bus_we, bus_re, bus_wdata, bus_wstrb, tx_ready,
        output bus_rdata, bus_sel, tx_data, tx_valid
    );
endinterface

// File: rtl/mmio_console.sv
// MMIO console: a three-register window (TXDATA, STATUS, EXIT) sitting above
// main memory. TXDATA stores feed a byte FIFO drained over a valid/ready
// stream; EXIT latches a sticky halt flag together with the program exit code.
module mmio_console #(
    parameter logic [31:0] BASE  = 32'h0000_4000,
    parameter int          DEPTH = 8              // power of two, >= 2
) (
    input  logic          clk,
    input  logic          rst,
    mmio_console_if.slave bus,
    output logic          halt,
    output logic [31:0]   exit_code
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_EXIT   = 2'd2;

    logic [7:0]    fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;

    logic          sel;
    logic [1:0]    offset;
    logic          empty;
    logic          full;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          exit_wr;
    logic [31:0]   status;

    // Address decode, FIFO handshake qualifiers and STATUS assembly.
    always_comb begin
        sel      = ({1'b0, bus.bus_addr} >= {1'b0, BASE}) &&
                   ({1'b0, bus.bus_addr} <  ({1'b0, BASE} + 33'd12));
        offset   = bus.bus_addr[3:2];
        empty    = (count == '0);
        full     = (count == CW'(DEPTH));
        pop      = !empty && bus.tx_ready;
        push_req = bus.bus_we && sel && (offset == OFF_TXDATA) && bus.bus_wstrb[0];
        // A full FIFO still accepts a byte when the head leaves on the same edge.
        push_ok  = push_req && (!full || pop);
        exit_wr  = bus.bus_we && sel && (offset == OFF_EXIT) &&
                   (bus.bus_wstrb != 4'b0000) && !halt;
        status   = {24'h0, halt, overflow, full, empty, 4'(count)};
    end

    // Bus-side outputs: load data is combinational and zero unless STATUS is read.
    always_comb begin
        bus.bus_sel   = sel;
        bus.bus_rdata = 32'h0;
        if (bus.bus_re && sel && (offset == OFF_STATUS)) begin
            bus.bus_rdata = status;
        end
        bus.tx_valid  = !empty;
        bus.tx_data   = fifo_mem[rd_ptr];
    end

    // FIFO storage: not reset, stale entries are never visible past rd_ptr.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= bus.bus_wdata[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Halt flag and exit code: the first EXIT store after reset wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            halt      <= 1'b0;
            exit_code <= 32'h0;
        end else if (exit_wr) begin
            halt      <= 1'b1;
            exit_code <= bus.bus_wdata;
        end
    end

endmodule

// File: tb/tb_mmio_console.sv
// Directed testbench for mmio_console with hand-computed expected values.
module tb_mmio_console;

    localparam logic [31:0] BASE = 32'h0000_4000;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic [31:0] exit_code;

    int vectors = 0;
    int errors  = 0;

    mmio_console_if bus ();

    mmio_console #(.BASE(BASE), .DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .halt      (halt),
        .exit_code (exit_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.bus_addr  = a;
        bus.bus_wdata = d;
        bus.bus_wstrb = s;
        bus.bus_we    = 1'b1;
        @(posedge clk);
        #1;
        bus.bus_we    = 1'b0;
        bus.bus_wstrb = 4'h0;
    endtask

    task automatic chk_status(input string tag, input logic [31:0] exp);
        bus.bus_addr = BASE + 32'd4;
        bus.bus_re   = 1'b1;
        #1;
        check(tag, bus.bus_rdata, exp);
        bus.bus_re   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.bus_addr  = 32'h0;
        bus.bus_we    = 1'b0;
        bus.bus_re    = 1'b0;
        bus.bus_wdata = 32'h0;
        bus.bus_wstrb = 4'h0;
        bus.tx_ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_exit_code", exit_code, 32'h0);
        chk_status("rst_status", 32'h10);

        // Single push, one-cycle latency
        bus.bus_addr = BASE;
        #1;
        check("sel_base", 32'(bus.bus_sel), 32'd1);
        wr(BASE, 32'h0000_0041, 4'h1);
        check("push1_valid", 32'(bus.tx_valid), 32'd1);
        check("push1_data", 32'(bus.tx_data), 32'h41);
        chk_status("push1_status", 32'h01);
        bus.bus_addr = BASE;
        bus.bus_re   = 1'b1;
        #1;
        check("txdata_read_zero", bus.bus_rdata, 32'h0);
        bus.bus_re   = 1'b0;
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        check("pop1_valid", 32'(bus.tx_valid), 32'd0);

        // Push without wstrb[0] is ignored
        wr(BASE, 32'h0000_0099, 4'b1110);
        chk_status("nostrb_status", 32'h10);

        // Overflow: 9 pushes into an 8-deep FIFO
        for (int i = 0; i < 9; i++) begin
            wr(BASE, 32'h30 + 32'(i), 4'h1);
        end
        chk_status("ovf_status", 32'h68);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain_data_%0d", i), 32'(bus.tx_data), 32'h30 + 32'(i));
            tick();
        end
        bus.tx_ready = 1'b0;
        check("drain_empty", 32'(bus.tx_valid), 32'd0);
        chk_status("drain_status", 32'h50);

        // Clear overflow, then push+pop while full
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr(BASE, 32'h60 + 32'(i), 4'h1);
        end
        chk_status("full_status", 32'h28);
        bus.tx_ready = 1'b1;
        wr(BASE, 32'h0000_0055, 4'h1);
        bus.tx_ready = 1'b0;
        chk_status("fullpp_status", 32'h28);
        check("fullpp_head", 32'(bus.tx_data), 32'h61);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check($sformatf("fullpp_data_%0d", i), 32'(bus.tx_data), 32'h61 + 32'(i));
            tick();
        end
        check("fullpp_last", 32'(bus.tx_data), 32'h55);
        tick();
        bus.tx_ready = 1'b0;
        check("fullpp_empty", 32'(bus.tx_valid), 32'd0);

        // EXIT: zero wstrb ignored, first exit wins
        wr(BASE + 32'd8, 32'h0000_0011, 4'h0);
        check("exit_nostrb_halt", 32'(halt), 32'd0);
        wr(BASE + 32'd8, 32'h0000_002A, 4'hF);
        check("exit_halt", 32'(halt), 32'd1);
        check("exit_code1", exit_code, 32'h2A);
        wr(BASE + 32'd8, 32'h0000_0007, 4'hF);
        check("exit_code2", exit_code, 32'h2A);
        chk_status("halt_status", 32'h90);

        // Pushes continue after halt, then reset mid-queue with a simultaneous push
        for (int i = 0; i < 3; i++) begin
            wr(BASE, 32'h71 + 32'(i), 4'h1);
        end
        chk_status("halt_push_status", 32'h83);
        check("halt_push_data", 32'(bus.tx_data), 32'h71);
        rst = 1'b1;
        wr(BASE, 32'h0000_0074, 4'h1);
        rst = 1'b0;
        check("rst2_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst2_halt", 32'(halt), 32'd0);
        check("rst2_exit_code", exit_code, 32'h0);
        chk_status("rst2_status", 32'h10);

        // Stores outside the window
        bus.bus_addr = BASE + 32'd12;
        #1;
        check("sel_base12", 32'(bus.bus_sel), 32'd0);
        bus.bus_addr = BASE - 32'd4;
        #1;
        check("sel_base_m4", 32'(bus.bus_sel), 32'd0);
        wr(BASE + 32'd12, 32'h0000_0042, 4'hF);
        wr(BASE - 32'd4, 32'h0000_0043, 4'hF);
        check("oow_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("oow_halt", 32'(halt), 32'd0);
        chk_status("oow_status", 32'h10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
